// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared state encoding and default constants for the ADC scan controller
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR_SET = 3'd1,
    START_HI = 3'd2,
    WAIT_LO  = 3'd3,
    WAIT_HI  = 3'd4,
    OE_HI    = 3'd5,
    NEXT     = 3'd6,
    DONE     = 3'd7
  } adc_state_t;

  localparam int DEF_CLK_DIV = 6250;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 3;

  // States during which the ADC owns a channel and the address must be held
  function automatic logic is_active(input adc_state_t s);
    return (s == ADDR_SET) || (s == START_HI) || (s == WAIT_LO) ||
           (s == WAIT_HI)  || (s == OE_HI);
  endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// rtl/adc_tick_gen.sv - single-clk enable pulse every CLK_DIV system clocks
module adc_tick_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  // Width never drops to zero so CLK_DIV=1 still has a legal counter
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  // Compare at full integer width so the terminal count is never truncated
  assign w_wrap = (int'(r_cnt) == CLK_DIV - 1);
  assign tick   = w_wrap;

  // Free-running divider counter, 0..CLK_DIV-1
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - round-robin multiplexed ADC scan controller with EOC timeout
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int CH_NUM      = 8,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int EOC_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sample_enable,
  input  logic              single_mode,
  input  logic              EOC,
  input  logic [DATA_W-1:0] adc_data,
  output logic              ALE,
  output logic              start,
  output logic              OE,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] data_ch,
  output logic              data_valid,
  output logic              timeout_err,
  output logic              busy
);

  localparam int TW = $clog2(EOC_TIMEOUT + 1);

  logic              w_tick;
  adc_state_t        r_state;
  adc_state_t        w_next;
  logic [ADDR_W-1:0] r_ch;
  logic [ADDR_W-1:0] w_ch_next;
  logic [TW-1:0]     r_to;
  logic [TW-1:0]     w_to_next;
  logic              w_capture;
  logic              w_timeout;
  logic              w_last_ch;
  logic              w_to_hit;

  logic              r_ale;
  logic              r_start;
  logic              r_oe;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_data_ch;
  logic              r_valid;
  logic              r_timeout;
  logic              r_busy;

  adc_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .tick (w_tick)
  );

  assign w_last_ch = (int'(r_ch) == CH_NUM - 1);
  assign w_to_hit  = (int'(r_to) + 1 == EOC_TIMEOUT);

  // Next state, next channel and next timeout count; EOC transitions are
  // tested before the timeout so a coincident EOC edge always wins
  always_comb begin
    w_next    = r_state;
    w_ch_next = r_ch;
    w_to_next = r_to;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (sample_enable) begin
          w_next = ADDR_SET;
        end
      end
      ADDR_SET: begin
        w_next = START_HI;
      end
      START_HI: begin
        w_next    = WAIT_LO;
        w_to_next = '0;
      end
      WAIT_LO: begin
        if (!EOC) begin
          w_next    = WAIT_HI;
          w_to_next = '0;
        end else if (w_to_hit) begin
          w_next    = NEXT;
          w_timeout = 1'b1;
        end else begin
          w_to_next = r_to + TW'(1);
        end
      end
      WAIT_HI: begin
        if (EOC) begin
          w_next = OE_HI;
        end else if (w_to_hit) begin
          w_next    = NEXT;
          w_timeout = 1'b1;
        end else begin
          w_to_next = r_to + TW'(1);
        end
      end
      OE_HI: begin
        w_next    = NEXT;
        w_capture = 1'b1;
      end
      NEXT: begin
        if (single_mode && w_last_ch) begin
          w_next    = DONE;
          w_ch_next = '0;
        end else if (sample_enable) begin
          w_next    = ADDR_SET;
          w_ch_next = w_last_ch ? '0 : r_ch + ADDR_W'(1);
        end else begin
          w_next    = IDLE;
          w_ch_next = '0;
        end
      end
      DONE: begin
        if (!sample_enable) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next    = IDLE;
        w_ch_next = '0;
      end
    endcase
  end

  // State, channel and timeout registers advance only on tick edges
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_to    <= '0;
    end else if (w_tick) begin
      r_state <= w_next;
      r_ch    <= w_ch_next;
      r_to    <= w_to_next;
    end
  end

  // Registered outputs decoded from the next state; pulses last one clk
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ale     <= 1'b0;
      r_start   <= 1'b0;
      r_oe      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_data_ch <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      if (w_tick) begin
        r_ale     <= (w_next == ADDR_SET) || (w_next == START_HI);
        r_start   <= (w_next == START_HI);
        r_oe      <= (w_next == OE_HI);
        r_addr    <= is_active(w_next) ? w_ch_next : '0;
        r_busy    <= (w_next != IDLE) && (w_next != DONE);
        r_valid   <= w_capture;
        r_timeout <= w_timeout;
        if (w_capture) begin
          r_data    <= adc_data;
          r_data_ch <= r_addr;
        end
      end
    end
  end

  assign ALE         = r_ale;
  assign start       = r_start;
  assign OE          = r_oe;
  assign addr        = r_addr;
  assign data_out    = r_data;
  assign data_ch     = r_data_ch;
  assign data_valid  = r_valid;
  assign timeout_err = r_timeout;
  assign busy        = r_busy;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb/tb_adc_scan_ctrl.sv - scoreboard bench for adc_scan_ctrl
module tb_adc_scan_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: CH_NUM=4, CLK_DIV=1, EOC_TIMEOUT=4
  logic          rstn, sample_enable, single_mode;
  logic          eoc = 1'b1;
  logic [DW-1:0] adc_data;
  logic          ale, start, oe, data_valid, timeout_err, busy;
  logic [AW-1:0] addr, data_ch;
  logic [DW-1:0] data_out;

  adc_scan_ctrl #(
    .CH_NUM(4), .ADDR_W(AW), .DATA_W(DW), .CLK_DIV(1), .EOC_TIMEOUT(4)
  ) u_dut (
    .clk(clk), .rstn(rstn), .sample_enable(sample_enable), .single_mode(single_mode),
    .EOC(eoc), .adc_data(adc_data), .ALE(ale), .start(start), .OE(oe), .addr(addr),
    .data_out(data_out), .data_ch(data_ch), .data_valid(data_valid),
    .timeout_err(timeout_err), .busy(busy)
  );

  // Second instance: CH_NUM=3, CLK_DIV=5, used for reset-abort and tick alignment
  logic          rstn5;
  logic          eoc5 = 1'b1;
  logic [DW-1:0] adc5;
  logic          ale5, start5, oe5, valid5, to5, busy5;
  logic [AW-1:0] addr5, ch5;
  logic [DW-1:0] dout5;

  adc_scan_ctrl #(
    .CH_NUM(3), .ADDR_W(AW), .DATA_W(DW), .CLK_DIV(5), .EOC_TIMEOUT(255)
  ) u_dut5 (
    .clk(clk), .rstn(rstn5), .sample_enable(1'b1), .single_mode(1'b0),
    .EOC(eoc5), .adc_data(adc5), .ALE(ale5), .start(start5), .OE(oe5), .addr(addr5),
    .data_out(dout5), .data_ch(ch5), .data_valid(valid5),
    .timeout_err(to5), .busy(busy5)
  );

  // ADC models: data bus only meaningful while OE is high
  assign adc_data = oe  ? (8'h10 + {5'b0, addr}) : 8'hEE;
  assign adc5     = oe5 ? 8'hA0 : 8'hEE;

  int k = 100;
  int lo_at = 2;
  int hi_at = 5;
  bit stuck1 = 1'b0;
  int k5 = 100;

  // EOC falls lo_at ticks after start and rises again at hi_at
  always @(posedge clk) begin
    #1;
    if (start) k = 0; else if (k < 100) k++;
    eoc = (stuck1 && addr == 3'd1) ? 1'b1 : !(k >= lo_at && k < hi_at);
    if (start5) k5 = 0; else if (k5 < 100) k5++;
    eoc5 = !(k5 >= 5 && k5 < 15);
  end

  typedef struct {
    bit to;
    int ch;
    int data;
    int sgap;
    int vgap;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_start = 0;
  int   last_valid = 0;
  logic prev_start = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor: pops one expected event per data_valid / timeout_err pulse
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rstn === 1'b1) begin
      if (start && !prev_start) last_start = cyc;
      if (!start && prev_start) begin
        n_vec++;
        if (cyc - last_start != 1) begin
          n_err++;
          $display("FAIL start_width: got %0d clks, want 1", cyc - last_start);
        end
      end
      if (data_valid || timeout_err) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: valid=%0b timeout=%0b ch=%0d data=%0h, want none",
                   data_valid, timeout_err, data_ch, data_out);
        end else begin
          e = exp_q.pop_front();
          if (timeout_err !== e.to || data_valid !== !e.to) begin
            n_err++;
            $display("FAIL event_kind: valid=%0b timeout=%0b, want timeout=%0b",
                     data_valid, timeout_err, e.to);
          end else if (!e.to && (int'(data_ch) != e.ch || int'(data_out) != e.data)) begin
            n_err++;
            $display("FAIL sample: ch=%0d data=%0h, want ch=%0d data=%0h",
                     data_ch, data_out, e.ch, e.data);
          end else if (cyc - last_start != e.sgap) begin
            n_err++;
            $display("FAIL start_to_event: got %0d ticks, want %0d", cyc - last_start, e.sgap);
          end else if (!e.to && e.vgap != 0 && cyc - last_valid != e.vgap) begin
            n_err++;
            $display("FAIL valid_period: got %0d ticks, want %0d", cyc - last_valid, e.vgap);
          end
        end
        if (data_valid) last_valid = cyc;
      end
    end
    prev_start = start;
  end

  function automatic void pv(input int ch, input int sg, input int vg);
    exp_t e;
    e.to = 1'b0; e.ch = ch; e.data = 16 + ch; e.sgap = sg; e.vgap = vg;
    exp_q.push_back(e);
  endfunction

  function automatic void pt(input int sg);
    exp_t e;
    e.to = 1'b1; e.ch = 0; e.data = 0; e.sgap = sg; e.vgap = 0;
    exp_q.push_back(e);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_ev(input bit want_to, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step(1);
      if (want_to ? timeout_err : data_valid) hit = 1'b1;
    end
    if (!hit) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no event within 60 clks, want one", tag);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    bit early;
    int first_start;
    rstn = 1'b0; rstn5 = 1'b0; sample_enable = 1'b0; single_mode = 1'b0;
    step(4);
    chk("reset_ctrl", int'({ale, start, oe, busy, data_valid, timeout_err}), 0);
    chk("reset_addr", int'(addr), 0);
    chk("reset_data", int'({data_out, data_ch}), 0);
    rstn = 1'b1; rstn5 = 1'b1;
    step(2);

    // Continuous scan of 4 channels, nominal EOC timing
    pv(0, 7, 0);
    for (int c = 1; c < 4; c++) pv(c, 7, 9);
    pv(0, 7, 9);
    sample_enable = 1'b1;
    repeat (5) wait_ev(1'b0, "cont_valid");
    sample_enable = 1'b0;
    step(10);
    chk("cont_idle_busy", int'(busy), 0);

    // EOC edges coincide with the timeout in both waits: EOC wins
    lo_at = 4; hi_at = 8;
    pv(0, 10, 0);
    sample_enable = 1'b1;
    wait_ev(1'b0, "coincide_valid");
    sample_enable = 1'b0;
    step(10);

    // EOC rise one tick too late: timeout in WAIT_HI
    hi_at = 9;
    pt(9);
    sample_enable = 1'b1;
    wait_ev(1'b1, "late_timeout");
    sample_enable = 1'b0;
    step(10);
    lo_at = 2; hi_at = 5;

    // EOC stuck high on channel 1
    stuck1 = 1'b1;
    pv(0, 7, 0); pt(5); pv(2, 7, 16);
    sample_enable = 1'b1;
    wait_ev(1'b0, "stuck_ch0");
    wait_ev(1'b1, "stuck_timeout");
    wait_ev(1'b0, "stuck_ch2");
    sample_enable = 1'b0;
    stuck1 = 1'b0;
    step(10);

    // Single-mode scans and re-arm
    single_mode = 1'b1;
    pv(0, 7, 0);
    for (int c = 1; c < 4; c++) pv(c, 7, 9);
    sample_enable = 1'b1;
    repeat (4) wait_ev(1'b0, "single_valid");
    step(20);
    chk("single_done_busy", int'(busy), 0);
    chk("single_done_addr", int'(addr), 0);
    sample_enable = 1'b0;
    step(3);
    pv(0, 7, 0);
    for (int c = 1; c < 4; c++) pv(c, 7, 9);
    sample_enable = 1'b1;
    repeat (4) wait_ev(1'b0, "rearm_valid");
    step(5);
    chk("rearm_done_busy", int'(busy), 0);
    sample_enable = 1'b0;
    single_mode = 1'b0;
    step(5);

    // Enable dropped while in WAIT_HI: current channel still completes
    pv(0, 7, 0);
    sample_enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      if (start) seen = 1'b1;
    end
    chk("drop_start_seen", int'(seen), 1);
    step(4);
    sample_enable = 1'b0;
    wait_ev(1'b0, "drop_valid");
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (start) seen = 1'b1;
    end
    chk("drop_no_restart", int'(seen), 0);
    chk("drop_idle_ctrl", int'({ale, start, oe, busy, data_valid, timeout_err}), 0);
    chk("drop_idle_addr", int'(addr), 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    // Reset pulse during OE_HI on the CLK_DIV=5 instance
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step(1);
      if (oe5) seen = 1'b1;
    end
    chk("div5_oe_seen", int'(seen), 1);
    rstn5 = 1'b0;
    step(1);
    chk("div5_rst_oe", int'(oe5), 0);
    chk("div5_rst_busy", int'(busy5), 0);
    chk("div5_rst_valid", int'({valid5, to5}), 0);
    chk("div5_rst_data", int'({dout5, ch5}), 0);
    rstn5 = 1'b1;
    early = 1'b0;
    seen = 1'b0;
    first_start = 0;
    for (int c = 1; c <= 12; c++) begin
      step(1);
      if (c < 5 && ale5) early = 1'b1;
      if (c == 5) begin
        chk("div5_ale_at_5", int'(ale5), 1);
        chk("div5_addr_at_5", int'(addr5), 0);
      end
      if (start5 && first_start == 0) first_start = c;
      if (valid5) seen = 1'b1;
    end
    chk("div5_ale_early", int'(early), 0);
    chk("div5_first_start", first_start, 10);
    chk("div5_no_valid", int'(seen), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
